// File: rtl/counter_updn.sv
// Parametrised up/down counter with load, wrap-or-saturate limits, a combinational
// terminal-count flag for cascading, and registered wrap/saturate status.
module counter_updn #(
    parameter int WIDTH    = 8,
    parameter int MOD_MAX  = 255,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cnt,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] qout,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic at_max;
    logic at_zero;

    assign at_max  = (qout == MAX_VAL);
    assign at_zero = (qout == '0);

    // Combinational so a following stage can use it as its count enable in the same cycle.
    assign tc = cnt & ((up & at_max) | (~up & at_zero));

    // Priority per edge: clr, then load, then count, then hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            qout <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else if (load) begin
            qout <= (num > MAX_VAL) ? MAX_VAL : num;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else if (cnt) begin
            if (up) begin
                if (!at_max) begin
                    qout <= qout + ONE;
                    wrap <= 1'b0;
                    sat  <= 1'b0;
                end else if (SATURATE) begin
                    wrap <= 1'b0;
                    sat  <= 1'b1;
                end else begin
                    qout <= '0;
                    wrap <= 1'b1;
                    sat  <= 1'b0;
                end
            end else begin
                if (!at_zero) begin
                    qout <= qout - ONE;
                    wrap <= 1'b0;
                    sat  <= 1'b0;
                end else if (SATURATE) begin
                    wrap <= 1'b0;
                    sat  <= 1'b1;
                end else begin
                    // Wrap to MOD_MAX explicitly; a non-power-of-two range cannot rely on underflow.
                    qout <= MAX_VAL;
                    wrap <= 1'b1;
                    sat  <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
            sat  <= 1'b0;
        end
    end

endmodule
